// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// DIV_MIN is the shortest legal period. Ratios below it are promoted to it.
// The helpers work on 32-bit values, so callers must keep DIV_W <= 32.
package clk_div_pkg;

    localparam int DIV_MIN   = 2;

    localparam int DEF_NCH   = 4;
    localparam int DEF_DIV_W = 16;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_STEP  = 10;

    // Effective divide ratio: 0 and 1 cannot produce a distinct high and low phase.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

    // Number of high cycles per period. Odd ratios get the extra cycle high.
    // The sum is taken in 33 bits so that d = 2^32-1 does not overflow.
    function automatic logic [31:0] high_len(input logic [31:0] d);
        logic [32:0] s;
        s = {1'b0, d} + 33'd1;
        return s[32:1];
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: ratio register, phase counter, divided level, period tick,
// and an optional accumulator that adds STEP for every cycle the level is high.
// The accumulator is built only when MULTI_CLK_DIV_EVCNT_EN is defined. Otherwise
// ev_cnt_o reads 0 and clr has no effect.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en,
    input  logic             clr,
    output logic             clk_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] ev_cnt_o
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] h_len;
    logic [DIV_W-1:0] d_last;
    logic             clk_q;
    logic             tick_q;

    assign d_eff  = DIV_W'(eff_div(32'(div_q)));
    assign h_len  = DIV_W'(high_len(32'(d_eff)));
    assign d_last = d_eff - ONE;

    // Ratio latch and phase generation. Load restarts the period. When en is low,
    // the counter and level freeze but the tick is suppressed.
    // cnt_q is zeroed whenever div_q changes, so it never starts above d_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (load) begin
            div_q  <= div_i;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (en) begin
            cnt_q  <= (cnt_q == d_last) ? '0 : cnt_q + ONE;
            clk_q  <= (cnt_q < h_len);
            tick_q <= (cnt_q == d_last);
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

`ifdef MULTI_CLK_DIV_EVCNT_EN
    localparam logic [CNT_W-1:0] STEP_T = CNT_W'(STEP);

    logic [CNT_W-1:0] ev_q;

    // Level-sensitive accumulator. It follows the registered level, so it lags
    // clk_o by one cycle. It runs regardless of en, and clear wins over add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else if (clr) begin
            ev_q <= '0;
        end else if (clk_q) begin
            ev_q <= ev_q + STEP_T;
        end
    end

    assign ev_cnt_o = ev_q;
`else
    localparam logic [CNT_W-1:0] unused_step = CNT_W'(STEP);

    logic unused_clr;
    assign unused_clr = clr;
    assign ev_cnt_o   = '0;
`endif

endmodule

// File: rtl/multi_clk_div.sv
// NCH independent clock dividers driven from one system clock. A single shared
// load latches every ratio and restarts every channel.
// Define MULTI_CLK_DIV_EVCNT_EN to build the per-channel event accumulators.
// Without it, ev_cnt_o is tied to 0 and the port list stays the same.
module multi_clk_div
    import clk_div_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int STEP  = DEF_STEP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [NCH*DIV_W-1:0] div_i,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       clk_o,
    output logic [NCH-1:0]       tick_o,
    output logic [NCH*CNT_W-1:0] ev_cnt_o
);

    // One channel per slice of the packed buses.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        clk_div_ch #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W),
            .STEP  (STEP)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .div_i    (div_i[c*DIV_W +: DIV_W]),
            .en       (en[c]),
            .clr      (clr[c]),
            .clk_o    (clk_o[c]),
            .tick_o   (tick_o[c]),
            .ev_cnt_o (ev_cnt_o[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div: 4 channels, 16-bit ratios, 8-bit accumulators, STEP = 10.
module tb_multi_clk_div;

`ifdef MULTI_CLK_DIV_EVCNT_EN
    localparam bit EV_EN = 1'b1;
`else
    localparam bit EV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [63:0] div_i;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [3:0]  clk_o;
    logic [3:0]  tick_o;
    logic [31:0] ev_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    multi_clk_div #(
        .NCH   (4),
        .DIV_W (16),
        .CNT_W (8),
        .STEP  (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .div_i    (div_i),
        .en       (en),
        .clr      (clr),
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .ev_cnt_o (ev_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ev_exp(input logic [31:0] v);
        return EV_EN ? v : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ec;
        logic [3:0] et;

        rst_n = 1'b0;
        load  = 1'b0;
        div_i = '0;
        en    = 4'hF;
        clr   = 4'h0;

        // reset values, then the default ratio of 2 runs from the first edge
        #12;
        chk("rst_clk", 32'(clk_o), 32'h0);
        chk("rst_tick", 32'(tick_o), 32'h0);
        chk("rst_ev", ev_cnt_o, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("def_clk", 32'(clk_o), (i % 2 == 1) ? 32'hF : 32'h0);
            chk("def_tick", 32'(tick_o), (i % 2 == 1) ? 32'h0 : 32'hF);
        end
        chk("def_ev", ev_cnt_o, ev_exp({4{8'd20}}));

        // ratios 5, 3, 0, 1; div_i changes after load must be ignored
        div_i = {16'd1, 16'd0, 16'd3, 16'd5};
        load  = 1'b1;
        clr   = 4'hF;
        step();
        chk("load_clk", 32'(clk_o), 32'h0);
        chk("load_tick", 32'(tick_o), 32'h0);
        chk("load_ev", ev_cnt_o, 32'h0);
        load  = 1'b0;
        clr   = 4'h0;
        div_i = {4{16'd7}};
        for (int i = 1; i <= 15; i++) begin
            step();
            ec[0] = ((i - 1) % 5) < 3;
            et[0] = (i % 5) == 0;
            ec[1] = ((i - 1) % 3) != 2;
            et[1] = (i % 3) == 0;
            ec[2] = (i % 2) == 1;
            et[2] = (i % 2) == 0;
            ec[3] = ec[2];
            et[3] = et[2];
            chk("ratio_clk", 32'(clk_o), 32'(ec));
            chk("ratio_tick", 32'(tick_o), 32'(et));
        end
        chk("ratio_ev", ev_cnt_o, ev_exp({8'd70, 8'd70, 8'd100, 8'd90}));

        // ch0 D=4: freeze for 3 cycles while high
        div_i = {16'd2, 16'd2, 16'd2, 16'd4};
        load  = 1'b1;
        clr   = 4'hF;
        step();
        load  = 1'b0;
        clr   = 4'h0;
        step();
        chk("frz_pre_clk", 32'(clk_o[0]), 32'd1);
        en = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_clk", 32'(clk_o[0]), 32'd1);
            chk("frz_tick", 32'(tick_o[0]), 32'd0);
        end
        chk("frz_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd30));
        en = 4'hF;
        step();
        chk("res5_clk", 32'(clk_o[0]), 32'd1);
        chk("res5_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd40));
        step();
        chk("res6_clk", 32'(clk_o[0]), 32'd0);
        chk("res6_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd50));
        step();
        chk("res7_clk", 32'(clk_o[0]), 32'd0);
        chk("res7_tick", 32'(tick_o[0]), 32'd1);
        step();
        chk("res8_clk", 32'(clk_o[0]), 32'd1);
        chk("res8_tick", 32'(tick_o[0]), 32'd0);

        // ch0 D=4: accumulate 8 cycles, then clear while high
        load = 1'b1;
        clr  = 4'hF;
        step();
        load = 1'b0;
        clr  = 4'h0;
        repeat (8) step();
        chk("acc8_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd40));
        step();
        chk("acc9_clk", 32'(clk_o[0]), 32'd1);
        chk("acc9_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd40));
        clr = 4'b0001;
        step();
        chk("clr_ev", 32'(ev_cnt_o[7:0]), 32'd0);
        clr = 4'h0;
        step();
        chk("post_clr_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd10));

        // D=2 everywhere: run the 8-bit accumulator up to 250, then wrap to 4
        div_i = {4{16'd2}};
        load  = 1'b1;
        clr   = 4'hF;
        step();
        load  = 1'b0;
        clr   = 4'h0;
        repeat (50) step();
        chk("pre_wrap_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd250));
        repeat (2) step();
        chk("wrap_ev", 32'(ev_cnt_o[7:0]), ev_exp(32'd4));

        // asynchronous reset while clk_o is high
        step();
        chk("pre_rst_clk", 32'(clk_o), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_o), 32'h0);
        chk("arst_tick", 32'(tick_o), 32'h0);
        chk("arst_ev", ev_cnt_o, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_clk", 32'(clk_o), 32'hF);
        chk("post_rst_tick", 32'(tick_o), 32'h0);
        step();
        chk("post_rst2_clk", 32'(clk_o), 32'h0);
        chk("post_rst2_tick", 32'(tick_o), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
